// File: rtl/vga_pkg.sv
// 640x480 VGA timing constants, pixel type and a constant-multiply helper.
// Latency: none (declarations only).
// Backpressure: none.
package vga_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // val * k for a constant k, unrolled into shifted adds so no multiplier is built.
    function automatic logic [12:0] mul_const(input logic [9:0] val, input int k);
        logic [12:0] acc;
        acc = '0;
        for (int i = 0; i < 13; i++) begin
            if (k[i]) acc = acc + (13'(val) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical scan counters with raw sync/visible flags.
// Latency: flags are combinational from the counters; counters step one tick after each tick.
// Backpressure: none; free-running once out of reset.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       frame_start
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0] div_cnt;
    logic       tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            hcount  <= '0;
            vcount  <= '0;
        end else begin
            div_cnt <= tick ? 2'd0 : div_cnt + 2'd1;
            if (tick) begin
                if (hcount == H_TOTAL - 10'd1) begin
                    hcount <= '0;
                    vcount <= (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign hsync   = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
    assign vsync   = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
    assign visible = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

    // Only the first clock of pixel (0,0) so the pulse stays one clock wide for any divider.
    assign frame_start = (hcount == 10'd0) && (vcount == 10'd0) && (div_cnt == 2'd0);

endmodule

// File: rtl/vga_framebuffer.sv
// 24-bit framebuffer scanned out as 640x480 VGA, each word covering an 8x8 pixel block.
// Latency: outputs trail the scan counters by 2 clocks (address register, RAM/output register).
// Backpressure: none; writes are accepted every clock and never disturb timing.
module vga_framebuffer
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int FB_WIDTH  = 80,
    parameter int FB_HEIGHT = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_we,
    input  logic [12:0] vga_addr,
    input  logic [23:0] vga_data,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        video_on,
    output logic        frame_start
);

    localparam int          FB_DEPTH   = FB_WIDTH * FB_HEIGHT;
    localparam logic [13:0] FB_DEPTH_W = 14'(FB_DEPTH);

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        t_hsync;
    logic        t_vsync;
    logic        t_visible;
    logic        t_frame_start;

    vga_timing #(
        .CLK_DIV(CLK_DIV)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .hsync      (t_hsync),
        .vsync      (t_vsync),
        .visible    (t_visible),
        .frame_start(t_frame_start)
    );

    logic [12:0] rd_addr;
    assign rd_addr = mul_const(vcount >> 3, FB_WIDTH) + 13'(hcount >> 3);

    logic [12:0] s1_addr;
    logic        s1_vis;
    logic        s1_hsync;
    logic        s1_vsync;
    logic        s1_fs;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_addr  <= '0;
            s1_vis   <= 1'b0;
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            s1_fs    <= 1'b0;
        end else begin
            s1_addr  <= t_visible ? rd_addr : 13'd0;
            s1_vis   <= t_visible;
            s1_hsync <= t_hsync;
            s1_vsync <= t_vsync;
            s1_fs    <= t_frame_start;
        end
    end

    // Simple dual-port RAM, read-first; contents deliberately survive reset.
    pixel_t mem [FB_DEPTH];
    pixel_t ram_q;
    logic   wr_ok;

    assign wr_ok = vga_we && ({1'b0, vga_addr} < FB_DEPTH_W);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[vga_addr] <= pixel_t'(vga_data);
        ram_q <= mem[s1_addr];
    end

    logic s2_vis;
    logic s2_hsync;
    logic s2_vsync;
    logic s2_fs;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vis   <= 1'b0;
            s2_hsync <= 1'b1;
            s2_vsync <= 1'b1;
            s2_fs    <= 1'b0;
        end else begin
            s2_vis   <= s1_vis;
            s2_hsync <= s1_hsync;
            s2_vsync <= s1_vsync;
            s2_fs    <= s1_fs;
        end
    end

    // The RAM register has no reset, so blanking gates colour to zero outside the visible area.
    assign video_on    = s2_vis;
    assign hsync       = s2_hsync;
    assign vsync       = s2_vsync;
    assign frame_start = s2_fs;
    assign red         = s2_vis ? ram_q.r : 8'd0;
    assign green       = s2_vis ? ram_q.g : 8'd0;
    assign blue        = s2_vis ? ram_q.b : 8'd0;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Scoreboard bench: two framebuffers (pixel divider 1 and 2) share one write/reset stream.
// Expected outputs come from a reference scan model and a memory model.
module tb_vga_framebuffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_we;
    logic [12:0] vga_addr;
    logic [23:0] vga_data;

    logic       hsync0, vsync0, video_on0, frame_start0;
    logic [7:0] red0, green0, blue0;
    logic       hsync1, vsync1, video_on1, frame_start1;
    logic [7:0] red1, green1, blue1;

    always #5 clk = ~clk;

    vga_framebuffer #(.CLK_DIV(1), .FB_WIDTH(80), .FB_HEIGHT(60)) dut0 (
        .clk(clk), .rst(rst), .vga_we(vga_we), .vga_addr(vga_addr), .vga_data(vga_data),
        .hsync(hsync0), .vsync(vsync0), .red(red0), .green(green0), .blue(blue0),
        .video_on(video_on0), .frame_start(frame_start0)
    );

    vga_framebuffer #(.CLK_DIV(2), .FB_WIDTH(80), .FB_HEIGHT(60)) dut1 (
        .clk(clk), .rst(rst), .vga_we(vga_we), .vga_addr(vga_addr), .vga_data(vga_data),
        .hsync(hsync1), .vsync(vsync1), .red(red1), .green(green1), .blue(blue1),
        .video_on(video_on1), .frame_start(frame_start1)
    );

    // Output vector layout: {hsync, vsync, video_on, frame_start, R, G, B}
    logic [27:0] o [2];
    assign o[0] = {hsync0, vsync0, video_on0, frame_start0, red0, green0, blue0};
    assign o[1] = {hsync1, vsync1, video_on1, frame_start1, red1, green1, blue1};

    localparam logic [27:0] INACTIVE = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

    typedef struct {
        logic [27:0] e;
        int          h;
        int          v;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [23:0] mem_m [0:4799];
    int          mh[2], mv[2], md[2];

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    logic        prev_hs[2], prev_vis[2], vis_ok[2];
    int          last_fall[2], low_run[2], vis_run[2], fs_cnt[2];
    logic        pulsed;
    logic [23:0] old5, w2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [27:0] expect_px(input int h, input int v, input int d);
        logic        vis, hs, vs, fs;
        logic [23:0] rgb;
        vis = (h < 640) && (v < 480);
        hs  = !((h >= 656) && (h < 752));
        vs  = !((v >= 490) && (v < 492));
        fs  = (h == 0) && (v == 0) && (d == 0);
        rgb = vis ? mem_m[(v / 8) * 80 + h / 8] : 24'h0;
        return {hs, vs, vis, fs, rgb};
    endfunction

    task automatic reset_model(input int i);
        exp_t ex;
        ex.e = INACTIVE; ex.h = -1; ex.v = -1;
        mh[i] = 0; mv[i] = 0; md[i] = 0;
        if (i == 0) begin q0.delete(); q0.push_back(ex); q0.push_back(ex); end
        else        begin q1.delete(); q1.push_back(ex); q1.push_back(ex); end
    endtask

    task automatic score(input int i, input exp_t ex);
        if (ex.h < 0) check_val($sformatf("reset_out%0d", i), o[i], ex.e);
        else          check_val($sformatf("pix%0d_h%0d_v%0d", i, ex.h, ex.v), o[i], ex.e);
        if (i == 0 && ex.h >= 0) begin
            if (ex.h == 3  && ex.v == 3)  check_val("red_block",   o[0][23:0], 24'hFF0000);
            if (ex.h == 12 && ex.v == 12) check_val("green_block", o[0][23:0], 24'h00FF00);
            if (ex.h == 16 && ex.v == 0)  check_val("px16_word2",  o[0][23:0], w2);
            if (ex.h == 40 && ex.v == 0)  check_val("rdfirst_now", o[0][23:0], pulsed ? 24'h0000FF : old5);
            if (ex.h == 40 && ex.v == 1)  check_val("rdfirst_next", o[0][23:0], 24'h0000FF);
        end
    endtask

    task automatic measure(input int i);
        logic hs, vis;
        hs  = o[i][27];
        vis = o[i][25];
        if (prev_hs[i] && !hs) begin
            if (last_fall[i] >= 0) check_val($sformatf("hs_period%0d", i), cyc - last_fall[i], 800 * div_of(i));
            last_fall[i] = cyc;
            low_run[i]   = 0;
        end
        if (!hs) low_run[i]++;
        if (!prev_hs[i] && hs && low_run[i] > 0) begin
            check_val($sformatf("hs_low%0d", i), low_run[i], 96 * div_of(i));
            low_run[i] = 0;
        end
        if (!prev_vis[i] && vis) begin vis_ok[i] = 1'b1; vis_run[i] = 0; end
        if (vis) vis_run[i]++;
        if (prev_vis[i] && !vis && vis_ok[i]) check_val($sformatf("vis_run%0d", i), vis_run[i], 640 * div_of(i));
        if (o[i][24]) fs_cnt[i]++;
        prev_hs[i]  = hs;
        prev_vis[i] = vis;
    endtask

    // One clock: compare outputs, drive next-edge stimulus, push expectation for current counters.
    task automatic step(input logic r, input logic we, input logic [12:0] a, input logic [23:0] d);
        exp_t ex;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                check_val($sformatf("sb_empty%0d", i), 32'd1, 32'd0);
            end else begin
                ex = (i == 0) ? q0.pop_front() : q1.pop_front();
                score(i, ex);
            end
            measure(i);
        end
        rst = r; vga_we = we; vga_addr = a; vga_data = d;
        if (we && a < 13'd4800) mem_m[a] = d;
        for (int i = 0; i < 2; i++) begin
            ex.e = expect_px(mh[i], mv[i], md[i]);
            ex.h = mh[i];
            ex.v = mv[i];
            if (i == 0) q0.push_back(ex); else q1.push_back(ex);
            if (r) begin
                reset_model(i);
            end else if (md[i] == div_of(i) - 1) begin
                md[i] = 0;
                if (mh[i] == 799) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == 524) ? 0 : mv[i] + 1;
                end else begin
                    mh[i]++;
                end
            end else begin
                md[i]++;
            end
        end
    endtask

    initial begin
        logic        r, we;
        logic [12:0] a;
        logic [23:0] d;
        logic        done5;

        rst = 1'b1; vga_we = 1'b0; vga_addr = '0; vga_data = '0;
        pulsed = 1'b0; done5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prev_hs[i] = 1'b1; prev_vis[i] = 1'b0; vis_ok[i] = 1'b0;
            last_fall[i] = -1; low_run[i] = 0; vis_run[i] = 0; fs_cnt[i] = 0;
            reset_model(i);
        end
        repeat (2) @(posedge clk);

        // Fill the first eight framebuffer rows while held in reset.
        for (int k = 0; k < 640; k++) begin
            d = (k == 0) ? 24'hFF0000 : (k == 81) ? 24'h00FF00 : 24'($urandom);
            step(1'b1, 1'b1, 13'(k), d);
        end
        old5 = mem_m[5];
        w2   = mem_m[2];

        for (int c = 0; c < 32000 && errs <= 40; c++) begin
            r = 1'b0; we = 1'b0; a = '0; d = '0;
            if (!done5 && mh[0] == 41 && mv[0] == 0) begin
                we = 1'b1; a = 13'd5; d = 24'h0000FF; done5 = 1'b1;
            end else if (mv[0] == 2 && mh[0] == 100) begin
                we = 1'b1; a = 13'd4800; d = 24'hFFFFFF;
            end else if (mv[0] == 2 && mh[0] == 101) begin
                we = 1'b1; a = 13'd8191; d = 24'hFFFFFF;
            end else if (mv[0] >= 4 && mh[0] == 700) begin
                we = 1'b1; a = 13'($urandom_range(100, 639)); d = 24'($urandom);
            end
            if (!pulsed && mv[0] == 10 && mh[0] == 300) begin
                r = 1'b1; pulsed = 1'b1;
                for (int i = 0; i < 2; i++) begin last_fall[i] = -1; vis_ok[i] = 1'b0; end
            end
            step(r, we, a, d);
        end

        check_val("fs_count0", fs_cnt[0], 2);
        check_val("fs_count1", fs_cnt[1], 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end

endmodule
